// File: rtl/uart_cmd_ctrl_if.sv
// Handshake bundle between the UART command controller and its environment:
// byte receive/transmit streams, sensor measurement request, and busy status.
interface uart_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        meas_start;
  logic        meas_done;
  logic [15:0] meas_value;
  logic        busy;

  modport slave (
    input  rx_data, rx_valid, tx_ready, meas_done, meas_value,
    output rx_ready, tx_data, tx_valid, meas_start, busy
  );

  modport master (
    output rx_data, rx_valid, tx_ready, meas_done, meas_value,
    input  rx_ready, tx_data, tx_valid, meas_start, busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses 3-byte A5/CMD/CHK command frames, optionally triggers a sensor
// measurement, and answers with a 5-byte 5A/STATUS/D_HI/D_LO/CHK response.
module uart_cmd_ctrl #(
  parameter int unsigned BYTE_TIMEOUT = 100_000,
  parameter int unsigned MEAS_TIMEOUT = 1_000_000
) (
  input logic            clk,
  input logic            rstn,
  uart_cmd_ctrl_if.slave bus
);

  localparam logic [7:0]  SyncRx   = 8'hA5;
  localparam logic [7:0]  SyncTx   = 8'h5A;
  localparam logic [7:0]  CmdRead  = 8'h01;
  localparam logic [7:0]  CmdPing  = 8'h02;
  localparam logic [7:0]  StatOk   = 8'h00;
  localparam logic [7:0]  StatChk  = 8'hE1;
  localparam logic [7:0]  StatCmd  = 8'hE2;
  localparam logic [7:0]  StatTmo  = 8'hE3;
  localparam logic [31:0] ByteLast = 32'(BYTE_TIMEOUT - 1);
  localparam logic [31:0] MeasLast = 32'(MEAS_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StGetCmd, StGetChk, StMeasWait, StSend} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rx_ready_q, tx_valid_q, meas_start_q;
  logic        rx_fire, tx_fire, rx_state_d;
  logic [7:0]  tx_byte;

  assign rx_fire = bus.rx_valid && rx_ready_q;
  assign tx_fire = tx_valid_q && bus.tx_ready;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    status_d = status_q;
    data_d   = data_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rx_fire && (bus.rx_data == SyncRx)) begin
          state_d = StGetCmd;
          cnt_d   = '0;
        end
      end
      StGetCmd: begin
        if (rx_fire) begin
          cmd_d   = bus.rx_data;
          state_d = StGetChk;
          cnt_d   = '0;
        end else if (cnt_q >= ByteLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StGetChk: begin
        if (rx_fire) begin
          cnt_d   = '0;
          idx_d   = '0;
          data_d  = '0;
          state_d = StSend;
          if (bus.rx_data != (SyncRx ^ cmd_q)) begin
            status_d = StatChk;
          end else if (cmd_q == CmdPing) begin
            status_d = StatOk;
          end else if (cmd_q == CmdRead) begin
            state_d = StMeasWait;
          end else begin
            status_d = StatCmd;
          end
        end else if (cnt_q >= ByteLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StMeasWait: begin
        // A completion landing on the expiry cycle still counts as success.
        if (bus.meas_done) begin
          status_d = StatOk;
          data_d   = bus.meas_value;
          state_d  = StSend;
          cnt_d    = '0;
        end else if (cnt_q >= MeasLast) begin
          status_d = StatTmo;
          data_d   = '0;
          state_d  = StSend;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StSend: begin
        if (tx_fire) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_state_d = (state_d == StIdle) || (state_d == StGetCmd) || (state_d == StGetChk);

  // Handshake outputs are registered so they read 0 throughout reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      status_q     <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      rx_ready_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      meas_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      status_q     <= status_d;
      data_q       <= data_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rx_ready_q   <= rx_state_d;
      tx_valid_q   <= (state_d == StSend);
      meas_start_q <= (state_q == StGetChk) && (state_d == StMeasWait);
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    if (tx_valid_q) begin
      unique case (idx_q)
        3'd0:    tx_byte = SyncTx;
        3'd1:    tx_byte = status_q;
        3'd2:    tx_byte = data_q[15:8];
        3'd3:    tx_byte = data_q[7:0];
        3'd4:    tx_byte = SyncTx ^ status_q ^ data_q[15:8] ^ data_q[7:0];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_byte;
  assign bus.meas_start = meas_start_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: command frames in, response frames out,
// measurement handshake, timeouts, back-pressure and reset behaviour.
module tb_uart_cmd_ctrl;
  localparam int unsigned BT = 16;
  localparam int unsigned MT = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(.BYTE_TIMEOUT(BT), .MEAS_TIMEOUT(MT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int vectors = 0;
  int errors = 0;
  int meas_pulses = 0;

  always @(negedge clk) if (bus.meas_start === 1'b1) meas_pulses++;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = (bus.rx_ready === 1'b1);
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL rx_accept byte %h: rx_ready stayed low, required 1", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  // Captures handshaken tx bytes; reports hold violations and the handshake span.
  task automatic collect(input bit toggle, output logic [39:0] resp, output int hold_err,
                         output bit rx_seen, output logic post_valid, output int span);
    int n = 0;
    int first = -1;
    int last = -1;
    logic [7:0] held = 8'h00;
    bit pend = 0;
    resp = 'x;
    hold_err = 0;
    rx_seen = 0;
    for (int c = 0; c < 300 && n < 5; c++) begin
      @(negedge clk);
      if (pend && (bus.tx_valid !== 1'b1 || bus.tx_data !== held)) hold_err++;
      if (bus.tx_valid === 1'b1) begin
        if (bus.rx_ready !== 1'b0) rx_seen = 1;
        if (bus.tx_ready) begin
          resp = {resp[31:0], bus.tx_data};
          n++;
          pend = 0;
          if (first < 0) first = c;
          last = c;
        end else begin
          pend = 1;
          held = bus.tx_data;
        end
      end
      @(posedge clk); #1;
      bus.tx_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    @(negedge clk);
    post_valid = bus.tx_valid;
    span = (first < 0) ? -1 : last - first + 1;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.rx_ready, bus.tx_valid, bus.tx_data, bus.meas_start, bus.busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h start=%b busy=%b, required all 0",
               bus.rx_ready, bus.tx_valid, bus.tx_data, bus.meas_start, bus.busy);
    end
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.rx_ready, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: rx_ready=%b busy=%b, required 1 0", bus.rx_ready, bus.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ping();
    logic [39:0] r; int h; bit rs; logic pv; int sp; int m0;
    m0 = meas_pulses;
    send_frame(8'hA5, 8'h02, 8'hA7);
    collect(0, r, h, rs, pv, sp);
    vectors++;
    if (r !== 40'h5A0000005A) begin
      errors++; $display("FAIL ping_resp: got %h, required 5a0000005a", r);
    end
    vectors++;
    if (pv !== 1'b0) begin
      errors++; $display("FAIL ping_tail: tx_valid=%b after last byte, required 0", pv);
    end
    vectors++;
    if (meas_pulses - m0 !== 0) begin
      errors++; $display("FAIL ping_meas: %0d meas_start cycles, required 0", meas_pulses - m0);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] r; int h; bit rs; logic pv; int sp;
    send_frame(8'hA5, 8'h02, 8'hA7);
    collect(0, r, h, rs, pv, sp);
    vectors++;
    if (sp !== 5) begin
      errors++; $display("FAIL b2b_span: 5 bytes over %0d cycles, required 5", sp);
    end
    vectors++;
    if (r !== 40'h5A0000005A) begin
      errors++; $display("FAIL b2b_resp: got %h, required 5a0000005a", r);
    end
  endtask

  task automatic test_read();
    logic [39:0] r; int h; bit rs; logic pv; int sp; int m0; bit seen = 0;
    m0 = meas_pulses;
    send_frame(8'hA5, 8'h01, 8'hA4);
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = (bus.meas_start === 1'b1);
    end
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL read_start: meas_start never pulsed, required a pulse");
    end
    repeat (5) @(posedge clk);
    #1;
    bus.meas_done  = 1'b1;
    bus.meas_value = 16'h1234;
    @(posedge clk); #1;
    bus.meas_done  = 1'b0;
    bus.meas_value = 16'h0000;
    collect(0, r, h, rs, pv, sp);
    vectors++;
    if (r !== 40'h5A0012347C) begin
      errors++; $display("FAIL read_resp: got %h, required 5a0012347c", r);
    end
    vectors++;
    if (meas_pulses - m0 !== 1) begin
      errors++; $display("FAIL read_pulse: %0d meas_start cycles, required 1", meas_pulses - m0);
    end
  endtask

  task automatic test_errors();
    logic [39:0] r; int h; bit rs; logic pv; int sp; int m0;
    m0 = meas_pulses;
    send_frame(8'hA5, 8'h01, 8'h00);
    collect(0, r, h, rs, pv, sp);
    vectors++;
    if (r !== 40'h5AE10000BB) begin
      errors++; $display("FAIL err_chk: got %h, required 5ae10000bb", r);
    end
    send_frame(8'hA5, 8'h07, 8'hA2);
    collect(0, r, h, rs, pv, sp);
    vectors++;
    if (r !== 40'h5AE20000B8) begin
      errors++; $display("FAIL err_cmd: got %h, required 5ae20000b8", r);
    end
    vectors++;
    if (meas_pulses - m0 !== 0) begin
      errors++; $display("FAIL err_meas: %0d meas_start cycles, required 0", meas_pulses - m0);
    end
  endtask

  task automatic test_meas_timeout();
    logic [39:0] r; int h; bit rs; logic pv; int sp;
    send_frame(8'hA5, 8'h01, 8'hA4);
    collect(0, r, h, rs, pv, sp);
    vectors++;
    if (r !== 40'h5AE30000B9) begin
      errors++; $display("FAIL meas_tmo: got %h, required 5ae30000b9", r);
    end
    // A stray completion while idle must not start anything.
    bus.meas_done = 1'b1;
    bus.meas_value = 16'hBEEF;
    @(posedge clk); #1;
    bus.meas_done = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.tx_valid} !== 2'b00) begin
      errors++;
      $display("FAIL stray_done: busy=%b tx_valid=%b, required 0 0", bus.busy, bus.tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_timeout();
    logic [39:0] r; int h; bit rs; logic pv; int sp; bit txs = 0;
    send_byte(8'hA5);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b0) txs = 1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors++;
    if ({txs, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL byte_tmo: tx_seen=%b busy=%b, required 0 0", txs, bus.busy);
    end
    @(posedge clk); #1;
    send_frame(8'hA5, 8'h02, 8'hA7);
    collect(0, r, h, rs, pv, sp);
    vectors++;
    if (r !== 40'h5A0000005A) begin
      errors++; $display("FAIL byte_tmo_recover: got %h, required 5a0000005a", r);
    end
  endtask

  task automatic test_back_pressure();
    logic [39:0] r; int h; bit rs; logic pv; int sp;
    send_byte(8'h11);
    send_byte(8'hA5);
    repeat (20) @(posedge clk);
    #1;
    send_frame(8'hA5, 8'h02, 8'hA7);
    bus.rx_data  = 8'h33;
    bus.rx_valid = 1'b1;
    collect(1, r, h, rs, pv, sp);
    bus.rx_valid = 1'b0;
    vectors++;
    if (r !== 40'h5A0000005A) begin
      errors++; $display("FAIL bp_resp: got %h, required 5a0000005a", r);
    end
    vectors++;
    if (h !== 0) begin
      errors++; $display("FAIL bp_hold: %0d unstable stalled cycles, required 0", h);
    end
    vectors++;
    if (rs !== 1'b0) begin
      errors++; $display("FAIL bp_rx_ready: rx_ready seen high during send, required low");
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] r; int h; bit rs; logic pv; int sp; bit txs = 0;
    bus.tx_ready = 1'b0;
    send_frame(8'hA5, 8'h02, 8'hA7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.tx_valid !== 1'b1) begin
      errors++; $display("FAIL mid_stall: tx_valid=%b while stalled, required 1", bus.tx_valid);
    end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({bus.rx_ready, bus.tx_valid, bus.tx_data, bus.busy} !== 11'h000) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b data=%h busy=%b, required all 0",
               bus.rx_ready, bus.tx_valid, bus.tx_data, bus.busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b0) txs = 1;
    end
    vectors++;
    if (txs !== 1'b0) begin
      errors++; $display("FAIL mid_resend: tx_valid after reset, required none");
    end
    @(posedge clk); #1;
    send_frame(8'hA5, 8'h02, 8'hA7);
    collect(0, r, h, rs, pv, sp);
    vectors++;
    if (r !== 40'h5A0000005A) begin
      errors++; $display("FAIL mid_recover: got %h, required 5a0000005a", r);
    end
  endtask

  initial begin
    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.tx_ready   = 1'b1;
    bus.meas_done  = 1'b0;
    bus.meas_value = 16'h0000;
    test_reset();
    test_ping();
    test_back_to_back();
    test_read();
    test_errors();
    test_meas_timeout();
    test_byte_timeout();
    test_back_pressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter BYTE_TIMEOUT, default 100_000: idle cycles allowed between bytes of one command frame.
REQ-002 Parameter MEAS_TIMEOUT, default 1_000_000: cycles allowed from meas_start to meas_done.
REQ-003 Port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 Port rstn  input  1  reset, asynchronous and active-low.
REQ-005 Port rx_data  input  8  byte from the UART receiver.
REQ-006 Port rx_valid  input  1  rx_data is valid.
REQ-007 Port rx_ready  output  1  controller accepts a byte; a transfer occurs when rx_valid && rx_ready.
REQ-008 Port tx_data  output  8  byte to the UART transmitter.
REQ-009 Port tx_valid  output  1  tx_data is valid.
REQ-010 Port tx_ready  input  1  transmitter accepts a byte; a transfer occurs when tx_valid && tx_ready.
REQ-011 Port meas_start  output  1  one-cycle pulse requesting a sensor measurement.
REQ-012 Port meas_done  input  1  measurement complete; meas_value is valid in this cycle.
REQ-013 Port meas_value  input  16  measurement result.
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 The command frame is three bytes: 0xA5, CMD, CHK, where CHK = 0xA5 ^ CMD.
REQ-016 Supported commands: CMD 0x01 = read measurement, CMD 0x02 = ping.
REQ-017 The response frame is five bytes: 0x5A, STATUS, D_HI, D_LO, CHK, where CHK = XOR of the preceding four bytes.
REQ-018 The state set is IDLE, GET_CMD, GET_CHK, MEAS_WAIT, SEND.
REQ-019 rx_ready is high in IDLE, GET_CMD and GET_CHK, and low in MEAS_WAIT and SEND; bytes arriving during those two states are back-pressured, not dropped.
REQ-020 IDLE: an accepted 0xA5 moves to GET_CMD; any other accepted byte is discarded and the state stays IDLE.
REQ-021 GET_CMD: the accepted byte is stored as CMD and the state moves to GET_CHK.
REQ-022 GET_CHK, on the accepted byte:
- byte != 0xA5 ^ CMD: load response STATUS 0xE1, data 0x0000; go to SEND.
- checksum good, CMD 0x02: load STATUS 0x00, data 0x0000; go to SEND.
- checksum good, CMD 0x01: go to MEAS_WAIT.
- checksum good, any other CMD: load STATUS 0xE2, data 0x0000; go to SEND.
REQ-023 meas_start is high for exactly the first cycle spent in MEAS_WAIT.
REQ-024 MEAS_WAIT: meas_done high loads STATUS 0x00 and data meas_value, and moves to SEND.
REQ-025 MEAS_WAIT: if MEAS_TIMEOUT cycles elapse with no meas_done, load STATUS 0xE3, data 0x0000, and move to SEND.
REQ-026 meas_done in the same cycle as the timeout expiry takes priority over the timeout; meas_done outside MEAS_WAIT is ignored.
REQ-027 Byte timeout in GET_CMD/GET_CHK: the counter clears on each accepted byte. When it reaches BYTE_TIMEOUT, the state returns to IDLE and no response is sent.
REQ-028 SEND: tx_valid is asserted starting the cycle after SEND is entered. The five bytes are presented in order.
REQ-029 tx_data and tx_valid hold stable until the tx_ready handshake completes. The byte index advances only on a handshake.
REQ-030 After the handshake of byte 4, tx_valid is low the next cycle and the state returns to IDLE.
REQ-031 Back-to-back handshakes with tx_ready held high send one byte per cycle.
REQ-032 The response checksum is computed from the latched STATUS and data, and is independent of timing.

Reset
REQ-033 While rstn is low, regardless of clk: state = IDLE, all counters = 0, and stored CMD, STATUS and data = 0.
REQ-034 While rstn is low, outputs are: rx_ready = 0, tx_valid = 0, tx_data = 0x00, meas_start = 0, busy = 0.
REQ-035 The cycle after rstn deasserts: rx_ready = 1.
REQ-036 Reset mid-frame or mid-response abandons the frame; no partial byte is re-sent after reset.

Verification
REQ-037 Ping: rx A5 02 A7, tx_ready=1 -> tx 5A 00 00 00 5A; meas_start never pulses.
REQ-038 Read: rx A5 01 A4; meas_done with 0x1234 five cycles after meas_start -> single meas_start pulse, then tx 5A 00 12 34 7C.
REQ-039 Errors:
- rx A5 01 00 -> tx 5A E1 00 00 BB.
- rx A5 07 A2 -> tx 5A E2 00 00 B8.
REQ-040 Timeouts:
- rx A5 01 A4 with no meas_done (MEAS_TIMEOUT=16) -> tx 5A E3 00 00 B9.
- rx A5 then 20 silent cycles (BYTE_TIMEOUT=16) -> no tx, busy low, and a following A5 02 A7 is answered normally.
REQ-041 Back-pressure: tx_ready toggling randomly -> tx_data stable while tx_valid && !tx_ready; rx_valid during SEND sees rx_ready=0; garbage 11 A5 before a frame is discarded.
